// File: rtl/snn_buf_pkg.sv
// Shared defaults and word-layout helpers for the window line buffer.
package snn_buf_pkg;
    localparam int DEF_LANES  = 4;
    localparam int DEF_LANE_W = 16;
    localparam int DEF_ROWS   = 3;
    localparam int DEF_ADDR_W = 5;

    function automatic int word_w(input int lanes, input int rows, input int lane_w);
        return lanes * rows * lane_w;
    endfunction

    // Bit offset of lane l, row slot r; slot rows-1 holds the newest sample.
    function automatic int slot_lsb(input int l, input int r, input int rows, input int lane_w);
        return (l * rows + r) * lane_w;
    endfunction
endpackage

// File: rtl/buf_mem_1r1w.sv
// One-read one-write line memory, synchronous read and write, PD gates both ports.
module buf_mem_1r1w #(
    parameter int AW = 5,
    parameter int DW = 192
) (
    input  logic          CLK,
    input  logic          PD,
    input  logic          RE,
    input  logic [AW-1:0] RADDR,
    output logic [DW-1:0] RDATA,
    input  logic          WE,
    input  logic [AW-1:0] WADDR,
    input  logic [DW-1:0] WDATA
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    // Read returns the pre-write contents on an address collision.
    always_comb begin
        rdata_d = rdata_q;
        if (!PD && RE) rdata_d = mem[RADDR];
    end

    always_ff @(posedge CLK) begin
        rdata_q <= rdata_d;
        if (!PD && WE) mem[WADDR] <= WDATA;
    end

    assign RDATA = rdata_q;
endmodule

// File: rtl/window_buffer.sv
// Multi-lane line buffer producing a ROWS-tall window column per input sample.
module window_buffer
    import snn_buf_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int LANE_W = DEF_LANE_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                         CLK,
    input  logic                         RSTB,
    input  logic                         IN_VALID,
    input  logic [LANES*LANE_W-1:0]      IN_DATA,
    input  logic [ADDR_W-1:0]            DEPTH_M1,
    input  logic                         CLR,
    input  logic                         PD,
    output logic                         OUT_VALID,
    output logic [LANES*ROWS*LANE_W-1:0] OUT_DATA,
    output logic                         WIN_VALID
);
    localparam int WORD_W = word_w(LANES, ROWS, LANE_W);
    localparam int RCNT_W = $clog2(ROWS);
    localparam logic [RCNT_W-1:0] RCNT_MAX = RCNT_W'(ROWS - 1);

    logic [ADDR_W-1:0]       rptr_q, rptr_d, addr_q, addr_d;
    logic [RCNT_W-1:0]       rcnt_q, rcnt_d;
    logic                    pend_q, pend_d, win_q, win_d, fwd_q, fwd_d;
    logic [LANES*LANE_W-1:0] in_q, in_d;
    logic [WORD_W-1:0]       fwd_word_q, fwd_word_d, hold_q, hold_d;
    logic [WORD_W-1:0]       mem_rdata, rd_word, new_word;
    logic                    accept, out_fire;

    assign accept   = IN_VALID & ~PD & ~CLR;
    assign out_fire = pend_q & ~PD & ~CLR;
    assign rd_word  = fwd_q ? fwd_word_q : mem_rdata;

    buf_mem_1r1w #(.AW(ADDR_W), .DW(WORD_W)) u_mem (
        .CLK   (CLK),
        .PD    (PD),
        .RE    (accept),
        .RADDR (rptr_q),
        .RDATA (mem_rdata),
        .WE    (out_fire),
        .WADDR (addr_q),
        .WDATA (new_word)
    );

    always_comb begin
        new_word = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int r = 0; r < ROWS - 1; r++) begin
                new_word[slot_lsb(l, r, ROWS, LANE_W) +: LANE_W] =
                    rd_word[slot_lsb(l, r + 1, ROWS, LANE_W) +: LANE_W];
            end
            new_word[slot_lsb(l, ROWS - 1, ROWS, LANE_W) +: LANE_W] = in_q[l*LANE_W +: LANE_W];
        end
    end

    always_comb begin
        rptr_d     = rptr_q;
        rcnt_d     = rcnt_q;
        pend_d     = pend_q;
        win_d      = win_q;
        addr_d     = addr_q;
        in_d       = in_q;
        fwd_d      = fwd_q;
        fwd_word_d = fwd_word_q;
        hold_d     = hold_q;
        if (out_fire) hold_d = new_word;
        if (CLR) begin
            rptr_d = '0;
            rcnt_d = '0;
            pend_d = 1'b0;
        end else if (!PD) begin
            pend_d = IN_VALID;
            if (IN_VALID) begin
                addr_d     = rptr_q;
                in_d       = IN_DATA;
                win_d      = (rcnt_q == RCNT_MAX);
                // Same-cycle write to the address being read: take the write data.
                fwd_d      = out_fire && (addr_q == rptr_q);
                fwd_word_d = new_word;
                if (rptr_q >= DEPTH_M1) begin
                    rptr_d = '0;
                    if (rcnt_q != RCNT_MAX) rcnt_d = rcnt_q + 1'b1;
                end else begin
                    rptr_d = rptr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            rptr_q     <= '0;
            rcnt_q     <= '0;
            pend_q     <= 1'b0;
            win_q      <= 1'b0;
            addr_q     <= '0;
            in_q       <= '0;
            fwd_q      <= 1'b0;
            fwd_word_q <= '0;
            hold_q     <= '0;
        end else begin
            rptr_q     <= rptr_d;
            rcnt_q     <= rcnt_d;
            pend_q     <= pend_d;
            win_q      <= win_d;
            addr_q     <= addr_d;
            in_q       <= in_d;
            fwd_q      <= fwd_d;
            fwd_word_q <= fwd_word_d;
            hold_q     <= hold_d;
        end
    end

    assign OUT_VALID = out_fire;
    assign OUT_DATA  = out_fire ? new_word : hold_q;
    assign WIN_VALID = out_fire & win_q;
endmodule

// File: tb/tb_window_buffer.sv
// Directed bench for window_buffer: default build plus a 2-lane, 5-row build.
module tb_window_buffer;
    logic CLK = 1'b0;
    logic RSTB = 1'b0;
    always #5 CLK = ~CLK;

    logic         in_valid_a = 1'b0, clr_a = 1'b0, pd_a = 1'b0;
    logic [63:0]  in_data_a = '0;
    logic [4:0]   depth_a = 5'd3;
    logic         ov_a, wv_a;
    logic [191:0] od_a;

    logic         in_valid_b = 1'b0, clr_b = 1'b0, pd_b = 1'b0;
    logic [15:0]  in_data_b = '0;
    logic [2:0]   depth_b = 3'd7;
    logic         ov_b, wv_b;
    logic [79:0]  od_b;

    window_buffer u_dut_a (
        .CLK(CLK), .RSTB(RSTB), .IN_VALID(in_valid_a), .IN_DATA(in_data_a),
        .DEPTH_M1(depth_a), .CLR(clr_a), .PD(pd_a),
        .OUT_VALID(ov_a), .OUT_DATA(od_a), .WIN_VALID(wv_a)
    );

    window_buffer #(.LANES(2), .LANE_W(8), .ROWS(5), .ADDR_W(3)) u_dut_b (
        .CLK(CLK), .RSTB(RSTB), .IN_VALID(in_valid_b), .IN_DATA(in_data_b),
        .DEPTH_M1(depth_b), .CLR(clr_b), .PD(pd_b),
        .OUT_VALID(ov_b), .OUT_DATA(od_b), .WIN_VALID(wv_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic v;
        int   val;
        logic ev;
        logic ew;
        logic cd;
        int   e0, e1, e2;
    } vec_t;
    vec_t tab[12];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [191:0] exp_a(input int v0, input int v1, input int v2);
        logic [191:0] w;
        w = '0;
        for (int l = 0; l < 4; l++) begin
            w[(l*3+0)*16 +: 16] = v0[15:0];
            w[(l*3+1)*16 +: 16] = v1[15:0];
            w[(l*3+2)*16 +: 16] = v2[15:0];
        end
        return w;
    endfunction

    function automatic logic [79:0] exp_b(input int s);
        logic [79:0] w;
        int v;
        w = '0;
        for (int l = 0; l < 2; l++) begin
            for (int r = 0; r < 5; r++) begin
                v = s - 32 + 8 * r;
                w[(l*5+r)*8 +: 8] = v[7:0];
            end
        end
        return w;
    endfunction

    task automatic step_a(input logic v, input int val);
        in_valid_a = v;
        in_data_a  = {4{val[15:0]}};
        @(posedge CLK);
        #1;
    endtask

    task automatic step_b(input logic v, input int val);
        in_valid_b = v;
        in_data_b  = {2{val[7:0]}};
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_a();
        clr_a = 1'b1;
        step_a(1'b0, 0);
        clr_a = 1'b0;
    endtask

    // Twelve back-to-back samples base+1..base+12 at DEPTH_M1=3.
    task automatic run12(input string nm, input int base);
        for (int s = 1; s <= 12; s++) begin
            step_a(1'b1, base + s);
            chk({nm, "_ov"}, 256'(ov_a), 256'(1'b1));
            chk({nm, "_wv"}, 256'(wv_a), 256'(s >= 9));
            if (s >= 9) chk({nm, "_data"}, 256'(od_a), 256'(exp_a(base + s - 8, base + s - 4, base + s)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 1; s <= 12; s++) begin
            tab[s-1] = '{v: 1'b1, val: s, ev: 1'b1, ew: (s >= 9), cd: (s >= 9),
                         e0: s - 8, e1: s - 4, e2: s};
        end

        #23;
        chk("reset_ov", 256'(ov_a), 256'(1'b0));
        chk("reset_wv", 256'(wv_a), 256'(1'b0));
        chk("reset_data", 256'(od_a), 256'(0));
        RSTB = 1'b1;
        @(posedge CLK); #1;

        // Basic 3-row window at DEPTH_M1=3.
        depth_a = 5'd3;
        for (int i = 0; i < 12; i++) begin
            step_a(tab[i].v, tab[i].val);
            chk("tab_ov", 256'(ov_a), 256'(tab[i].ev));
            chk("tab_wv", 256'(wv_a), 256'(tab[i].ew));
            if (tab[i].cd) chk("tab_data", 256'(od_a), 256'(exp_a(tab[i].e0, tab[i].e1, tab[i].e2)));
        end
        step_a(1'b0, 0);
        chk("idle_ov", 256'(ov_a), 256'(1'b0));
        chk("idle_hold", 256'(od_a), 256'(exp_a(4, 8, 12)));

        // One-word line: every read collides with the previous write-back.
        clear_a();
        depth_a = 5'd0;
        step_a(1'b1, 5);
        chk("fwd1_wv", 256'(wv_a), 256'(1'b0));
        step_a(1'b1, 6);
        chk("fwd2_wv", 256'(wv_a), 256'(1'b0));
        step_a(1'b1, 7);
        chk("fwd3_ov", 256'(ov_a), 256'(1'b1));
        chk("fwd3_wv", 256'(wv_a), 256'(1'b1));
        chk("fwd3_data", 256'(od_a), 256'(exp_a(5, 6, 7)));
        step_a(1'b0, 0);

        // CLR overriding IN_VALID mid-line.
        clear_a();
        depth_a = 5'd3;
        for (int s = 1; s <= 5; s++) step_a(1'b1, 50 + s);
        step_a(1'b0, 0);
        clr_a = 1'b1;
        step_a(1'b1, 99);
        clr_a = 1'b0;
        chk("clr_ov", 256'(ov_a), 256'(1'b0));
        chk("clr_wv", 256'(wv_a), 256'(1'b0));
        run12("clr", 100);
        step_a(1'b0, 0);

        // Power-down with IN_VALID held high.
        clear_a();
        for (int s = 1; s <= 6; s++) step_a(1'b1, 200 + s);
        step_a(1'b0, 0);
        pd_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_a(1'b1, 77);
            chk("pd_ov", 256'(ov_a), 256'(1'b0));
            chk("pd_hold", 256'(od_a), 256'(exp_a(110, 202, 206)));
        end
        pd_a = 1'b0;
        for (int s = 7; s <= 12; s++) begin
            step_a(1'b1, 200 + s);
            chk("pd_resume_wv", 256'(wv_a), 256'(s >= 9));
            if (s >= 9) chk("pd_resume_data", 256'(od_a), 256'(exp_a(192 + s, 196 + s, 200 + s)));
        end

        // Reset one cycle after an accepted sample: its write-back must be dropped.
        step_a(1'b1, 99);
        in_valid_a = 1'b0;
        RSTB = 1'b0;
        #1;
        chk("rst_ov", 256'(ov_a), 256'(1'b0));
        chk("rst_wv", 256'(wv_a), 256'(1'b0));
        chk("rst_data", 256'(od_a), 256'(0));
        @(posedge CLK); #4;
        RSTB = 1'b1;
        @(posedge CLK); #1;
        step_a(1'b1, 301);
        chk("rst_after_wv", 256'(wv_a), 256'(1'b0));
        chk("rst_after_data", 256'(od_a), 256'(exp_a(205, 209, 301)));
        step_a(1'b0, 0);

        // Second build: 5 rows of 8 positions.
        for (int s = 1; s <= 40; s++) begin
            step_b(1'b1, s);
            chk("b_ov", 256'(ov_b), 256'(1'b1));
            chk("b_wv", 256'(wv_b), 256'(s >= 33));
            if (s >= 33) chk("b_data", 256'(od_b), 256'(exp_b(s)));
        end
        step_b(1'b0, 0);
        chk("b_idle_ov", 256'(ov_b), 256'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/window_buffer.md
WINDOW_BUFFER -- requirements
Module: window_buffer

Interface
REQ-001 SHALL have parameter LANES, default 4, number of independent input lanes.
REQ-002 SHALL have parameter LANE_W, default 16, bits per lane sample.
REQ-003 SHALL have parameter ROWS, default 3, window height (rows per output column), minimum 2.
REQ-004 SHALL have parameter ADDR_W, default 5, line-length address width; maximum line length 2^ADDR_W.
REQ-005 SHALL have ports:
- CLK  input  1  clock.
- RSTB  input  1  asynchronous active-low reset.
- IN_VALID  input  1  input sample strobe.
- IN_DATA  input  LANES*LANE_W  new sample; lane l at bits [l*LANE_W +: LANE_W].
- DEPTH_M1  input  ADDR_W  line length minus 1.
- CLR  input  1  synchronous restart.
- PD  input  1  power-down.
- OUT_VALID  output  1  OUT_DATA valid strobe.
- OUT_DATA  output  LANES*ROWS*LANE_W  window column.
- WIN_VALID  output  1  OUT_VALID with all ROWS rows filled.

Function
REQ-006 SHALL store one word per line position, LANES*ROWS*LANE_W bits; lane l row slot r at bits [(l*ROWS+r)*LANE_W +: LANE_W]; slot ROWS-1 newest.
REQ-007 SHALL, on IN_VALID=1 at cycle t (PD=0, CLR=0), read word at rptr and capture IN_DATA.
REQ-008 SHALL at t+1 drive OUT_DATA per lane: slots 0..ROWS-2 = stored slots 1..ROWS-1, slot ROWS-1 = captured IN_DATA; OUT_VALID=1 for that cycle only (latency 1).
REQ-009 SHALL write the t+1 OUT_DATA word back to the same line position at t+1.
REQ-010 SHALL accept IN_VALID every cycle with no stall; a read addressing the word written the same cycle SHALL return the word being written (forwarding; needed when DEPTH_M1=0).
REQ-011 SHALL advance rptr on each accepted sample; rptr >= DEPTH_M1 SHALL wrap to 0 (covers DEPTH_M1 lowered mid-line).
REQ-012 SHALL keep row counter rcnt, 0..ROWS-1: +1 on each rptr wrap, saturating at ROWS-1.
REQ-013 SHALL drive WIN_VALID = OUT_VALID and (rcnt == ROWS-1 at the sample's read cycle).
REQ-014 SHALL ignore IN_VALID while PD=1: no memory access, pointers/rcnt hold, OUT_VALID=0, OUT_DATA holds.
REQ-015 SHALL on CLR=1 set rptr=0, rcnt=0, cancel any pending write-back, OUT_VALID=0 next cycle; CLR SHALL override IN_VALID in the same cycle; memory contents not cleared.
REQ-016 SHALL hold OUT_DATA between OUT_VALID pulses.
REQ-017 SHALL treat DEPTH_M1 as quasi-static; changing it takes effect at next wrap compare per REQ-011.

Reset
REQ-018 SHALL on RSTB=0 asynchronously set rptr=0, rcnt=0, OUT_VALID=0, WIN_VALID=0, OUT_DATA=0, pending write-back cancelled.
REQ-019 SHALL not require memory contents reset; stale data only visible with WIN_VALID=0.
REQ-020 SHALL, on reset asserted mid-stream, drop the in-flight sample (no write-back).

Structure
REQ-021 SHALL place default LANES/LANE_W/ROWS/ADDR_W constants and word-width/slot-offset helper functions in shared package snn_buf_pkg.
REQ-022 SHALL use one sub-module buf_mem_1r1w (2^ADDR_W words, synchronous read, synchronous write, PD input gating both ports); forwarding lives in window_buffer.

Verification
REQ-023 SHALL cover: defaults, DEPTH_M1=3, samples s=1..12 (all lanes=s) back-to-back -> samples 9..12 give OUT_DATA lane slots {s-8,s-4,s}, WIN_VALID=1; samples 1..8 WIN_VALID=0.
REQ-024 SHALL cover: DEPTH_M1=0, IN_VALID every cycle, values 5,6,7 -> third output slots {5,6,7}, WIN_VALID=1 (forwarding).
REQ-025 SHALL cover: DEPTH_M1=3, 5 samples, CLR with IN_VALID same cycle, then 12 samples -> no OUT_VALID for CLR cycle, WIN_VALID first at new sample 9.
REQ-026 SHALL cover: PD=1 for 4 cycles with IN_VALID=1 mid-stream -> OUT_VALID=0, rptr/rcnt unchanged, stream resumes correctly after PD=0.
REQ-027 SHALL cover: RSTB pulse one cycle after an accepted sample -> outputs 0 immediately, that sample absent from later windows.
REQ-028 SHALL cover: LANES=2, LANE_W=8, ROWS=5, ADDR_W=3, DEPTH_M1=7 -> WIN_VALID first at sample 33, slots {s-32,s-24,s-16,s-8,s}.
